// File: rtl/pll_reconfig_seq.sv
// Reconfiguration sequencer for the fractional PLL: latches a counter profile,
// writes it over the Avalon-MM reconfig port, triggers reload, polls for
// completion and waits for lock with a timeout.
module pll_reconfig_seq #(
   parameter int unsigned NUM_CLOCKS   = 1,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned POLL_LIMIT   = 1023,
   parameter int unsigned CNT_W        = 18
) (
   input  logic                        refclk,
   input  logic                        rst,
   input  logic                        req,
   output logic                        ack,
   input  logic [CNT_W-1:0]            cfg_n,
   input  logic [CNT_W-1:0]            cfg_m,
   input  logic [NUM_CLOCKS*CNT_W-1:0] cfg_c,
   output logic [5:0]                  mgmt_address,
   output logic [31:0]                 mgmt_writedata,
   output logic                        mgmt_write,
   output logic                        mgmt_read,
   input  logic [31:0]                 mgmt_readdata,
   input  logic                        mgmt_waitrequest,
   input  logic                        pll_locked,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [1:0]                  err_code
);

   localparam int unsigned CW = NUM_CLOCKS * CNT_W;
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
   localparam int unsigned IW = 5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ACCEPT,
      S_WR_MODE,
      S_WR_N,
      S_WR_M,
      S_WR_C,
      S_WR_START,
      S_POLL,
      S_POLL_GAP,
      S_LOCK_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state;
   logic [1:0]       rst_q;
   logic             rst_i;
   logic [CNT_W-1:0] sh_n;
   logic [CNT_W-1:0] sh_m;
   logic [CW-1:0]    sh_c;
   logic [IW-1:0]    idx;
   logic [PW-1:0]    poll_cnt;
   logic [TW-1:0]    timer;
   logic [1:0]       lock_s;
   logic             unused_rd;

   assign unused_rd = ^mgmt_readdata[31:1];

   // Reset asserts immediately, releases two refclk edges after rst drops
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) rst_q <= 2'b11;
      else     rst_q <= {rst_q[0], 1'b0};
   end

   assign rst_i = rst_q[1];

   // Sequencer state, shadow profile, counters and lock synchroniser
   always_ff @(posedge refclk or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         sh_n     <= '0;
         sh_m     <= '0;
         sh_c     <= '0;
         idx      <= '0;
         poll_cnt <= '0;
         timer    <= '0;
         lock_s   <= '0;
         err_code <= '0;
      end else begin
         // Synchroniser is held clear outside LOCK_WAIT so lock always costs two cycles
         if (state == S_LOCK_WAIT) lock_s <= {lock_s[0], pll_locked};
         else                      lock_s <= 2'b00;

         case (state)
            S_IDLE: begin
               if (req) begin
                  sh_n     <= cfg_n;
                  sh_m     <= cfg_m;
                  sh_c     <= cfg_c;
                  idx      <= '0;
                  poll_cnt <= '0;
                  timer    <= '0;
                  err_code <= 2'd0;
                  state    <= S_ACCEPT;
               end
            end
            S_ACCEPT:  state <= S_WR_MODE;
            S_WR_MODE: if (!mgmt_waitrequest) state <= S_WR_N;
            S_WR_N:    if (!mgmt_waitrequest) state <= S_WR_M;
            S_WR_M:    if (!mgmt_waitrequest) state <= S_WR_C;
            S_WR_C: begin
               if (!mgmt_waitrequest) begin
                  sh_c <= sh_c >> CNT_W;
                  if (idx == IW'(NUM_CLOCKS - 1)) state <= S_WR_START;
                  else                            idx   <= idx + IW'(1);
               end
            end
            S_WR_START: if (!mgmt_waitrequest) state <= S_POLL;
            S_POLL: begin
               if (!mgmt_waitrequest) begin
                  if (mgmt_readdata[0]) begin
                     timer <= '0;
                     state <= S_LOCK_WAIT;
                  end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                     err_code <= 2'd1;
                     state    <= S_ERR;
                  end else begin
                     poll_cnt <= poll_cnt + PW'(1);
                     state    <= S_POLL_GAP;
                  end
               end
            end
            S_POLL_GAP: state <= S_POLL;
            S_LOCK_WAIT: begin
               if (lock_s[1]) begin
                  state <= S_DONE;
               end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                  err_code <= 2'd2;
                  state    <= S_ERR;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Bus strobes, address and data decoded from state and shadow registers only
   always_comb begin
      mgmt_address   = 6'h00;
      mgmt_writedata = 32'h0;
      mgmt_write     = 1'b0;
      mgmt_read      = 1'b0;
      case (state)
         S_WR_MODE: begin
            mgmt_address   = 6'h00;
            mgmt_writedata = 32'd1;
            mgmt_write     = 1'b1;
         end
         S_WR_N: begin
            mgmt_address   = 6'h03;
            mgmt_writedata = 32'(sh_n);
            mgmt_write     = 1'b1;
         end
         S_WR_M: begin
            mgmt_address   = 6'h04;
            mgmt_writedata = 32'(sh_m);
            mgmt_write     = 1'b1;
         end
         S_WR_C: begin
            mgmt_address   = 6'h05;
            mgmt_writedata = 32'({idx, sh_c[CNT_W-1:0]});
            mgmt_write     = 1'b1;
         end
         S_WR_START: begin
            mgmt_address   = 6'h02;
            mgmt_writedata = 32'h0;
            mgmt_write     = 1'b1;
         end
         S_POLL: begin
            mgmt_address   = 6'h01;
            mgmt_read      = 1'b1;
         end
         default: ;
      endcase
   end

   // Handshake and status pulses decoded from state
   assign ack  = (state == S_ACCEPT);
   assign done = (state == S_DONE);
   assign err  = (state == S_ERR);
   assign busy = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);

endmodule
